// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-side constants and bus record.
// Also used by the data-side memory stage.
package ifu_fetch_pkg;

  localparam logic [31:0] RESET_PC  = 32'h1c00_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [1:0]  SIZE_WORD = 2'b10;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
  } sram_rd_t;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: PC generation, inst_sram read
// requests, a one-entry IF slot and branch redirect.
module ifu_fetch
  import ifu_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        IFU_to_IDU_valid,
  input  logic        IDU_allow_in,
  output logic [31:0] IFU_pc_to_IDU,
  output logic [31:0] IFU_inst_to_IDU,
  input  logic        IDU_br_taken,
  input  logic        IDU_br_taken_cancel,
  input  logic [31:0] IDU_br_target
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        outst_q, outst_d;
  logic        drop_q, drop_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;

  logic if_fire, slot_free, req_acc;
  logic resp, resp_keep, cancel;

  assign cancel    = IDU_br_taken_cancel;
  assign if_fire   = if_valid_q & IDU_allow_in;
  assign slot_free = ~if_valid_q | if_fire;

  assign inst_sram_req = resetn & ~outst_q & slot_free
                       & ~IDU_br_taken & ~cancel;

  assign req_acc   = inst_sram_req & inst_sram_addr_ok;
  // A response with nothing outstanding is a protocol error; ignore it.
  assign resp      = inst_sram_data_ok & outst_q;
  assign resp_keep = resp & ~drop_q & ~cancel;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = SIZE_WORD;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = fetch_pc_q;

  assign IFU_to_IDU_valid = if_valid_q & ~cancel;
  assign IFU_pc_to_IDU    = if_pc_q;
  assign IFU_inst_to_IDU  = if_inst_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;

    if (req_acc) begin
      outst_d    = 1'b1;
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end

    if (resp) begin
      outst_d = 1'b0;
      drop_d  = 1'b0;
    end

    if (resp_keep) begin
      if_valid_d = 1'b1;
      if_pc_d    = req_pc_q;
      if_inst_d  = inst_sram_rdata;
    end else if (if_fire) begin
      if_valid_d = 1'b0;
    end

    // Redirect wins; a read still in flight comes back wrong-path.
    if (cancel) begin
      fetch_pc_d = IDU_br_target;
      if_valid_d = 1'b0;
      if (outst_q & ~inst_sram_data_ok) begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0;
      outst_q    <= 1'b0;
      drop_q     <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_inst_q  <= 32'h0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

endmodule
